// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide controller holding the HI/LO pair for the E stage.
// Define MD_DIV_EN to build div/divu; otherwise op 2/3 behave like reserved codes.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [1:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] hi_q, lo_q;

  logic        op_is_md;
  logic [3:0]  cnt_load;
  logic        sgn;
  logic [63:0] a_ext, b_ext, prod;
  logic        commit_en_d;
  logic [31:0] hi_d, lo_d;

`ifdef MD_DIV_EN
  assign op_is_md = ~op[2];
`else
  assign op_is_md = (op[2:1] == 2'b00);
`endif
  assign cnt_load = op[1] ? DIV_CNT : MULT_CNT;

  // op_q[0] clear selects the signed flavour for both mult and div.
  assign sgn   = ~op_q[0];
  assign a_ext = {{32{sgn & a_q[31]}}, a_q};
  assign b_ext = {{32{sgn & b_q[31]}}, b_q};
  assign prod  = a_ext * b_ext;

`ifdef MD_DIV_EN
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag;

  // Signed division runs on magnitudes; the quotient sign is the XOR of the
  // operand signs and the remainder follows the dividend. 0x80000000 / -1
  // lands on 0x80000000 naturally through this path.
  always_comb begin
    a_neg = sgn & a_q[31];
    b_neg = sgn & b_q[31];
    a_mag = a_neg ? (32'd0 - a_q) : a_q;
    b_mag = b_neg ? (32'd0 - b_q) : b_q;
    q_mag = 32'd0;
    r_mag = 32'd0;
    if (b_mag != 32'd0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
  end
`endif

  always_comb begin
    commit_en_d = 1'b0;
    hi_d        = hi_q;
    lo_d        = lo_q;
    if (!op_q[1]) begin
      commit_en_d = 1'b1;
      hi_d        = prod[63:32];
      lo_d        = prod[31:0];
    end
`ifdef MD_DIV_EN
    else if (b_q != 32'd0) begin
      commit_en_d = 1'b1;
      lo_d        = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
      hi_d        = a_neg ? (32'd0 - r_mag) : r_mag;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 2'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (op_is_md) begin
              op_q    <= op[1:0];
              a_q     <= rs;
              b_q     <= rt;
              cnt_q   <= cnt_load;
              state_q <= RUN;
            end else if (op == 3'd4) begin
              hi_q <= rs;
            end else if (op == 3'd5) begin
              lo_q <= rs;
            end
          end
        end
        RUN: begin
          // Commands arriving while running are dropped; the hazard unit stalls them.
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= IDLE;
            if (commit_en_d) begin
              hi_q <= hi_d;
              lo_q <= lo_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases plus random commands against an arithmetic model.
module tb_md_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs, rt;
  logic        busy;
  logic [31:0] hi, lo;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] hi_m, lo_m;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs(rs), .rt(rt), .busy(busy), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: what a command issued in IDLE does, from the arithmetic rules alone.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int n, output logic [31:0] eh, output logic [31:0] el);
    longint      q, r;
    logic [63:0] p;
    n  = 0;
    eh = hi_m;
    el = lo_m;
    case (o)
      3'd0: begin
        q  = longint'($signed(a)) * longint'($signed(b));
        p  = q;
        n  = MC; eh = p[63:32]; el = p[31:0];
      end
      3'd1: begin
        p  = {32'd0, a} * {32'd0, b};
        n  = MC; eh = p[63:32]; el = p[31:0];
      end
`ifdef MD_DIV_EN
      3'd2: begin
        n = DC;
        if (b != 32'd0) begin
          q  = longint'($signed(a)) / longint'($signed(b));
          r  = longint'($signed(a)) % longint'($signed(b));
          el = q[31:0]; eh = r[31:0];
        end
      end
      3'd3: begin
        n = DC;
        if (b != 32'd0) begin
          el = a / b; eh = a % b;
        end
      end
`endif
      3'd4: eh = a;
      3'd5: el = a;
      default: ;
    endcase
  endtask

  // Issue a command in the current cycle T; check busy and unchanged HI/LO for
  // T+1..T+N, then the committed result at T+N+1. inj_k injects an mtlo at T+inj_k,
  // noise adds random stray commands while busy.
  task automatic run_cmd(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int inj_k, input bit noise);
    int n;
    logic [31:0] eh, el;
    model(o, a, b, n, eh, el);
    start = 1'b1; op = o; rs = a; rt = b;
    tick();
    start = 1'b0;
    for (int k = 1; k <= n; k++) begin
      chk("busy_run", {31'd0, busy}, 32'd1);
      chk("hi_hold", hi, hi_m);
      chk("lo_hold", lo, lo_m);
      if (k == inj_k) begin
        start = 1'b1; op = 3'd5; rs = 32'h0000_1234; rt = 32'd0;
      end else if (noise && ($urandom_range(0, 1) == 1)) begin
        start = 1'b1; op = 3'($urandom_range(0, 7)); rs = $urandom; rt = $urandom;
      end
      tick();
      start = 1'b0;
    end
    chk("busy_done", {31'd0, busy}, 32'd0);
    chk("hi_result", hi, eh);
    chk("lo_result", lo, el);
    hi_m = eh;
    lo_m = el;
    $display("cmd op=%0d rs=%h rt=%h busy_cycles=%0d -> hi=%h lo=%h", o, a, b, n, hi, lo);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    start = 1'b0; op = 3'd0; rs = 32'd0; rt = 32'd0;
    reset = 1'b1;
    hi_m = 32'd0; lo_m = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);

    run_cmd(3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 0, 1'b0);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    run_cmd(3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 0, 1'b0);
    chk("multu_hi", hi, 32'h0000_0002);
    chk("multu_lo", lo, 32'hFFFF_FFFA);

`ifdef MD_DIV_EN
    run_cmd(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 0, 1'b0);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    run_cmd(3'd3, 32'h0000_0007, 32'h0000_0000, 0, 1'b0);
    chk("divu0_lo", lo, 32'hFFFF_FFFD);
    chk("divu0_hi", hi, 32'hFFFF_FFFF);
    run_cmd(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'h0000_0000);
`else
    run_cmd(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 0, 1'b0);
    chk("nodiv_lo", lo, 32'hFFFF_FFFA);
    chk("nodiv_hi", hi, 32'h0000_0002);
    run_cmd(3'd3, 32'h0000_0007, 32'h0000_0003, 0, 1'b0);
`endif

    run_cmd(3'd0, 32'h0000_1000, 32'h0000_0010, 2, 1'b0);
    chk("mtlo_ignored_lo", lo, 32'h0001_0000);
    run_cmd(3'd4, 32'h0000_ABCD, 32'd0, 0, 1'b0);
    chk("mthi_hi", hi, 32'h0000_ABCD);
    run_cmd(3'd6, 32'h5555_5555, 32'd1, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 :
           ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      run_cmd(ro, ra, rb, 0, 1'b1);
    end

    // Abort mid-operation: HI/LO were nonzero before, reset clears them and no write follows.
    run_cmd(3'd4, 32'h1357_9BDF, 32'd0, 0, 1'b0);
    run_cmd(3'd5, 32'h2468_ACE0, 32'd0, 0, 1'b0);
    start = 1'b1; rs = 32'h0000_0064; rt = 32'h0000_0007;
`ifdef MD_DIV_EN
    op = 3'd2;
`else
    op = 3'd0;
`endif
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    for (int k = 0; k < 12; k++) tick();
    chk("abort_busy_late", {31'd0, busy}, 32'd0);
    chk("abort_hi_late", hi, 32'd0);
    chk("abort_lo_late", lo, 32'd0);
    hi_m = 32'd0;
    lo_m = 32'd0;
    run_cmd(3'd0, 32'h0000_0003, 32'h0000_0005, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
